// File: rtl/text_stream_writer.sv
// rtl/text_stream_writer.sv - ASCII stream to 80x30 tile RAM writer with cursor and clear sweep
module text_stream_writer #(
    parameter int         MAX_X = 80,
    parameter int         MAX_Y = 30,
    parameter logic [6:0] BLANK = 7'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic        we,
    output logic [11:0] addr_w,
    output logic [6:0]  din,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [6:0] LAST_X = 7'(MAX_X - 1);
    localparam logic [4:0] LAST_Y = 5'(MAX_Y - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [0:0] state;
    logic [6:0] sweep_x;
    logic [4:0] sweep_y;
    logic       sweep_done;

    logic       accept;
    logic       is_print;
    logic [6:0] adv_x;
    logic [4:0] adv_y;
    logic [4:0] lf_y;

    assign ch_ready = (state == ST_IDLE);
    assign busy     = (state == ST_CLEAR);
    assign accept   = ch_valid && ch_ready;
    assign is_print = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

    // Cursor advance with explicit wrap at the screen limits (no scrolling)
    always_comb begin
        adv_x = cur_x;
        adv_y = cur_y;
        if (cur_x == LAST_X) begin
            adv_x = 7'd0;
            adv_y = (cur_y == LAST_Y) ? 5'd0 : cur_y + 5'd1;
        end else begin
            adv_x = cur_x + 7'd1;
        end
    end

    assign lf_y = (cur_y == LAST_Y) ? 5'd0 : cur_y + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_x      <= 7'd0;
            cur_y      <= 5'd0;
            we         <= 1'b0;
            addr_w     <= 12'd0;
            din        <= 7'd0;
            sweep_x    <= 7'd0;
            sweep_y    <= 5'd0;
            sweep_done <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            we     <= 1'b1;
                            addr_w <= {cur_y, cur_x};
                            din    <= ch_data[6:0];
                            cur_x  <= adv_x;
                            cur_y  <= adv_y;
                        end else if (ch_data == CH_CR) begin
                            cur_x <= 7'd0;
                        end else if (ch_data == CH_LF) begin
                            cur_y <= lf_y;
                        end else if (ch_data == CH_BS) begin
                            if (cur_x != 7'd0) begin
                                cur_x  <= cur_x - 7'd1;
                                we     <= 1'b1;
                                addr_w <= {cur_y, cur_x - 7'd1};
                                din    <= BLANK;
                            end
                        end else if (ch_data == CH_FF) begin
                            // Cell (0,0) is written on the accepting edge so the sweep
                            // starts in the very next cycle; counters point at (0,1).
                            cur_x      <= 7'd0;
                            cur_y      <= 5'd0;
                            we         <= 1'b1;
                            addr_w     <= 12'd0;
                            din        <= BLANK;
                            sweep_x    <= 7'd1;
                            sweep_y    <= 5'd0;
                            sweep_done <= 1'b0;
                            state      <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (sweep_done) begin
                        state <= ST_IDLE;
                    end else begin
                        we     <= 1'b1;
                        addr_w <= {sweep_y, sweep_x};
                        din    <= BLANK;
                        if (sweep_x == LAST_X) begin
                            sweep_x <= 7'd0;
                            if (sweep_y == LAST_Y) begin
                                sweep_done <= 1'b1;
                            end else begin
                                sweep_y <= sweep_y + 5'd1;
                            end
                        end else begin
                            sweep_x <= sweep_x + 7'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_stream_writer.sv
// tb/tb_text_stream_writer.sv - directed self-checking bench for text_stream_writer
module tb_text_stream_writer;

    logic        clk;
    logic        reset;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        we;
    logic [11:0] addr_w;
    logic [6:0]  din;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int wr_total = 0;

    bit seen [0:4095];
    int k, wcount, first_w, last_w, dups, badcol, baddin, busy_cycles, wr_snap;

    text_stream_writer dut (
        .clk      (clk),
        .reset    (reset),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .we       (we),
        .addr_w   (addr_w),
        .din      (din),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One byte, accepted at the next edge; returns at the following negedge
    task automatic send(input logic [7:0] b);
        ch_data  = b;
        ch_valid = 1'b1;
        @(posedge clk);
        #1 ch_valid = 1'b0;
        @(negedge clk);
        if (we) wr_total++;
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send(b);
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check_val({tag, "_x"}, 32'(cur_x), 32'(x));
        check_val({tag, "_y"}, 32'(cur_y), 32'(y));
    endtask

    initial begin
        logic [7:0] drops [5];
        drops[0] = 8'h07; drops[1] = 8'h85; drops[2] = 8'h7F;
        drops[3] = 8'h00; drops[4] = 8'h1F;

        reset = 1'b1; ch_valid = 1'b0; ch_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_we", 32'(we), 0);
        check_val("rst_addr", 32'(addr_w), 0);
        check_val("rst_din", 32'(din), 0);
        check_cursor("rst_cur", 0, 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_ready", 32'(ch_ready), 1);

        // Single printable byte
        send(8'h41);
        check_val("a_we", 32'(we), 1);
        check_val("a_addr", 32'(addr_w), 32'h000);
        check_val("a_din", 32'(din), 32'h41);
        check_cursor("a_cur", 1, 0);
        @(negedge clk);
        check_val("a_we_drop", 32'(we), 0);
        check_val("a_addr_hold", 32'(addr_w), 32'h000);

        // Row wrap from (78,0)
        send_n(8'h61, 77);
        check_cursor("pre78", 78, 0);
        send(8'h31); check_val("w78_addr", 32'(addr_w), 32'h04E);
        send(8'h32); check_val("w79_addr", 32'(addr_w), 32'h04F);
        send(8'h33); check_val("w80_addr", 32'(addr_w), 32'h080);
        check_val("w80_din", 32'(din), 32'h33);
        check_cursor("wrap_cur", 1, 1);

        // Screen wrap from (79,29)
        send_n(8'h62, 2318);
        check_cursor("pre_end", 79, 29);
        send(8'h63);
        check_val("end_we", 32'(we), 1);
        check_val("end_addr", 32'(addr_w), 32'hECF);
        check_cursor("end_cur", 0, 0);

        // Control codes without writes
        send_n(8'h78, 245);
        check_cursor("at53", 5, 3);
        wr_snap = wr_total;
        send(8'h0A); check_cursor("lf", 5, 4);
        send(8'h0D); check_cursor("cr", 0, 4);
        for (int i = 0; i < 5; i++) begin
            send(drops[i]);
            check_cursor($sformatf("drop%0h", drops[i]), 0, 4);
        end
        send(8'h08); check_cursor("bs_col0", 0, 4);
        check_val("nowrite_cnt", 32'(wr_total - wr_snap), 0);

        // Backspace
        send_n(8'h78, 5);
        send(8'h08);
        check_val("bs_we", 32'(we), 1);
        check_val("bs_addr", 32'(addr_w), 32'h204);
        check_val("bs_din", 32'(din), 32'h20);
        check_cursor("bs_cur", 4, 4);

        // LF wrap from last row
        send_n(8'h0A, 25);
        check_cursor("lf29", 4, 29);
        send(8'h0A);
        check_cursor("lf_wrap", 4, 0);

        // Clear with next byte already waiting
        for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
        wcount = 0; first_w = -1; last_w = -1; dups = 0; badcol = 0; baddin = 0; busy_cycles = 0;
        ch_data = 8'h0C; ch_valid = 1'b1;
        @(posedge clk);
        #1 ch_data = 8'h5A;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) check_cursor("ff_cur", 0, 0);
            if (busy && !ch_ready) busy_cycles++;
            if (we) begin
                if (first_w < 0) first_w = k;
                last_w = k;
                wcount++;
                if (addr_w[6:0] >= 7'd80 || addr_w[11:7] >= 5'd30) badcol++;
                else if (seen[addr_w]) dups++;
                seen[addr_w] = 1'b1;
                if (din != 7'h20) baddin++;
            end
        end while (!ch_ready && k < 3000);
        check_val("ff_ready_cycle", 32'(k), 2401);
        check_val("ff_busy_cycles", 32'(busy_cycles), 2400);
        check_val("ff_writes", 32'(wcount), 2400);
        check_val("ff_first", 32'(first_w), 1);
        check_val("ff_last", 32'(last_w), 2400);
        check_val("ff_dups", 32'(dups), 0);
        check_val("ff_badaddr", 32'(badcol), 0);
        check_val("ff_baddin", 32'(baddin), 0);
        @(posedge clk);
        #1 ch_valid = 1'b0;
        @(negedge clk);
        check_val("z_we", 32'(we), 1);
        check_val("z_addr", 32'(addr_w), 32'h000);
        check_val("z_din", 32'(din), 32'h5A);
        check_cursor("z_cur", 1, 0);

        // Reset in the middle of a clear
        ch_data = 8'h0C; ch_valid = 1'b1;
        @(posedge clk);
        #1 ch_valid = 1'b0;
        repeat (100) @(negedge clk);
        check_val("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_we", 32'(we), 0);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_addr", 32'(addr_w), 0);
        check_cursor("abort_cur", 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_ready", 32'(ch_ready), 1);
        check_val("abort_we2", 32'(we), 0);
        send(8'h42);
        check_val("b_we", 32'(we), 1);
        check_val("b_addr", 32'(addr_w), 32'h000);
        check_val("b_din", 32'(din), 32'h42);
        check_cursor("b_cur", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_stream_writer.md
# text_stream_writer

Character-stream writer for the 80x30 text-mode tile RAM. Accepts ASCII bytes over a valid/ready handshake, keeps its own cursor, and issues single-cycle writes on the tile RAM write port (address {row[4:0], col[6:0]}, 7-bit code). It interprets a small set of control codes: CR, LF, BS, and FF (clear screen). It is the producer side of the text display: the pixel-side generator reads the same RAM, and can use this block's cursor outputs for reverse-video highlighting.

## Interface
- MAX_X, 80: columns per row (640/8)
- MAX_Y, 30: rows per screen (480/16)
- BLANK, 7'h20: code written by BS and FF
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ch_valid  in  1  ch_data holds a character
- ch_data  in  8  ASCII byte
- ch_ready  out  1  block can accept; a byte transfers when ch_valid && ch_ready
- we  out  1  tile RAM write enable, one-cycle pulse per write
- addr_w  out  12  tile RAM write address {row[4:0], col[6:0]}
- din  out  7  tile RAM write data
- cur_x  out  7  cursor column, 0..MAX_X-1
- cur_y  out  5  cursor row, 0..MAX_Y-1
- busy  out  1  clear sweep in progress

## Operation
- States: IDLE and CLEAR. ch_ready = (state==IDLE), combinational. busy = (state==CLEAR).
- In IDLE, one byte can be accepted every cycle, so back-to-back transfers are legal. Each accepted byte is decoded as follows:
  - 0x20..0x7E (printable): write din=ch_data[6:0] at the current cursor, then advance the cursor.
  - Advance rule: col+1. If col==MAX_X-1, col=0 and row+1. If row==MAX_Y-1 on that wrap, row=0. There is no scrolling.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): row+1, wrapping MAX_Y-1 to 0. col is unchanged. No write.
  - 0x08 (BS): if col>0, col-1 and write BLANK at the new position. If col==0, nothing happens (no write, no cursor change).
  - 0x0C (FF): cursor goes to (0,0) and the block enters CLEAR.
  - Any other value (other 0x00..0x1F codes, 0x7F, bit 7 set): dropped silently, no write, no cursor change.
- CLEAR:
  - Separate sweep counters visit row 0..MAX_Y-1 and, within each row, col 0..MAX_X-1.
  - One BLANK write per cycle. Addresses with col >= MAX_X are never written.
  - After writing {MAX_Y-1, MAX_X-1}, the block returns to IDLE.
  - Bytes presented during CLEAR are held off by ch_ready=0.
- Width rules:
  - Cursor and sweep arithmetic is done at the native widths (7/5 bits), using explicit compare-to-limit wrap. Modulo-2^n wrap is never relied on.
  - addr_w is always {row, col} with no multiplication.

## Timing
- Reset values: state=IDLE, cur_x=0, cur_y=0, we=0, addr_w=0, din=0, busy=0, ch_ready=1 (as soon as reset deasserts).
- we, addr_w and din are registered.
- A byte accepted at edge N produces we=1 during cycle N+1, with addr_w equal to the cursor before the advance (for BS, the decremented position).
- cur_x and cur_y show the updated cursor in the same cycle N+1.
- we is 0 in every cycle that has no write. addr_w and din hold their last values when we=0.
- FF accepted at edge N:
  - ch_ready drops in cycle N+1.
  - Writes occupy cycles N+1 .. N+MAX_X*MAX_Y (2400 writes).
  - ch_ready returns high in cycle N+2401.
  - cur_x/cur_y read (0,0) from N+1 onward.
- FF accepted while the cursor is at any position gives the same sweep; the starting cursor is irrelevant.
- Reset asserted mid-CLEAR: immediate abort, with all registers at their reset values. Already-written cells stay written. No further writes occur.
- ch_valid dropping while ch_ready=1 is legal; no state changes in that case.

## Test plan
- After reset, send 'A' (0x41) -> exactly one we pulse, addr_w=12'h000, din=7'h41; then cur_x=1, cur_y=0.
- From cursor (78,0), send 3 printable bytes -> writes at {0,78}, {0,79}, {1,0}; final cursor (1,1). Separately, from (79,29) send 1 byte -> write at {29,79}, cursor (0,0).
- Cursor (5,3), send LF then CR -> cursor (5,4) then (0,4), with we never asserted. Send 0x07 and 0x85 -> no write, cursor unchanged.
- Cursor (5,3), send BS -> write BLANK (0x20) at {3,4}, cursor (4,3). At col 0, send BS -> no write, cursor unchanged.
- From cursor (10,10), send FF with ch_valid held high and the next byte 'Z' waiting -> exactly 2400 BLANK writes in consecutive cycles, covering all 80x30 addresses once and none with col>=80; busy high and ch_ready low for 2400 cycles; then 'Z' is accepted and written at {0,0}, cursor (1,0).
- Assert reset 100 cycles into a clear -> we=0 the next cycle, busy=0, cursor (0,0), ch_ready=1 after release. A subsequent 'B' is written at {0,0}.
